// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory read at a
// time and presents if_pc/if_inst/if_valid to the IF/ID register.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        jump_en,
   input  logic [31:0] jump_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_valid,
   output logic [2:0]  fsm_state
);

   // Memory handshake: imem_req is a one-cycle strobe with imem_addr; exactly one
   // imem_rvalid pulse answers it one or more cycles later, with no backpressure.
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;

   logic [2:0]  state;
   logic [2:0]  state_nxt;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_nxt;
   logic [31:0] hold_pc;
   logic [31:0] hold_inst;
   logic [31:0] jump_target;
   logic [31:0] dlv_pc;
   logic [31:0] dlv_inst;
   logic        deliver;
   logic        bubble;
   logic        hold_load;

   assign jump_target = {jump_addr[31:2], 2'b00};
   assign fsm_state   = state;

   always_comb begin
      state_nxt = state;
      fetch_nxt = fetch_pc;
      dlv_pc    = fetch_pc;
      dlv_inst  = imem_rdata;
      deliver   = 1'b0;
      bubble    = 1'b0;
      hold_load = 1'b0;
      if (jump_en) begin
         fetch_nxt = jump_target;
         // A request still in flight must be drained before the target is fetched.
         case (state)
            S_ISSUE: state_nxt = S_DRAIN;
            S_WAIT:  state_nxt = imem_rvalid ? S_ISSUE : S_DRAIN;
            S_DRAIN: state_nxt = imem_rvalid ? S_ISSUE : S_DRAIN;
            default: state_nxt = S_ISSUE;
         endcase
         // A redirect while draining and stalled leaves the outputs alone.
         bubble = (state != S_DRAIN) || !stall;
      end else begin
         case (state)
            S_IDLE: begin
               state_nxt = S_ISSUE;
               bubble    = !stall;
            end
            S_ISSUE: begin
               state_nxt = S_WAIT;
               bubble    = !stall;
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  fetch_nxt = fetch_pc + 32'd4;
                  if (!stall) begin
                     deliver   = 1'b1;
                     state_nxt = S_ISSUE;
                  end else begin
                     hold_load = 1'b1;
                     state_nxt = S_HOLD;
                  end
               end else begin
                  bubble = !stall;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  deliver   = 1'b1;
                  dlv_pc    = hold_pc;
                  dlv_inst  = hold_inst;
                  state_nxt = S_ISSUE;
               end
            end
            S_DRAIN: begin
               if (imem_rvalid) state_nxt = S_ISSUE;
               bubble = !stall;
            end
            default: begin
               state_nxt = S_IDLE;
               bubble    = !stall;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         fetch_pc  <= RESET_PC;
         hold_pc   <= RESET_PC;
         hold_inst <= 32'h00000000;
         if_pc     <= RESET_PC;
         if_inst   <= 32'h00000000;
         if_valid  <= 1'b0;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_nxt;
         if (hold_load) begin
            hold_pc   <= fetch_pc;
            hold_inst <= imem_rdata;
         end
         if (deliver) begin
            if_pc    <= dlv_pc;
            if_inst  <= dlv_inst;
            if_valid <= 1'b1;
         end else if (bubble) begin
            if_inst  <= 32'h00000000;
            if_valid <= 1'b0;
         end
         // The strobe is registered so it lines up with the ISSUE state.
         imem_req <= (state_nxt == S_ISSUE);
         if (state_nxt == S_ISSUE) imem_addr <= fetch_nxt;
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: startup, stall/skid, redirects, PC wrap and
// reset while a request is outstanding, against a latency-programmable memory.
module tb_if_fetch;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        jump_en;
   logic [31:0] jump_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_valid;
   logic [2:0]  fsm_state;

   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [31:0] mem_addr;
   int          mem_cnt;
   int          mem_lat;
   logic        mem_clr;
   logic        tb_rvalid;
   logic [31:0] tb_rdata;

   int checks;
   int errors;

   localparam logic [31:0] S_IDLE  = 32'd0;
   localparam logic [31:0] S_ISSUE = 32'd1;
   localparam logic [31:0] S_WAIT  = 32'd2;
   localparam logic [31:0] S_HOLD  = 32'd3;
   localparam logic [31:0] S_DRAIN = 32'd4;

   if_fetch #(.RESET_PC(32'h00000100)) dut (
      .clk(clk), .rst(rst), .stall(stall), .jump_en(jump_en), .jump_addr(jump_addr),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
      .fsm_state(fsm_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign imem_rvalid = mem_rvalid | tb_rvalid;
   assign imem_rdata  = tb_rvalid ? tb_rdata : mem_rdata;

   // Memory model: answers addr+1 mem_lat cycles after each request strobe.
   always @(negedge clk) begin
      mem_rvalid = 1'b0;
      if (mem_clr) begin
         mem_cnt = 0;
      end else begin
         if (mem_cnt > 0) begin
            mem_cnt = mem_cnt - 1;
            if (mem_cnt == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = mem_addr + 32'd1;
            end
         end
         if (imem_req) begin
            mem_cnt  = mem_lat;
            mem_addr = imem_addr;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                          input logic vld);
      chk({tag, ".pc"}, if_pc, pc);
      chk({tag, ".inst"}, if_inst, inst);
      chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, vld});
   endtask

   task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
      chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
      if (req) chk({tag, ".addr"}, imem_addr, addr);
   endtask

   task automatic do_reset(input int lat);
      rst     = 1'b0;
      mem_lat = lat;
      mem_clr = 1'b1;
      tick();
      mem_clr = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b0;
      stall     = 1'b0;
      jump_en   = 1'b0;
      jump_addr = 32'h0;
      tb_rvalid = 1'b0;
      tb_rdata  = 32'h0;
      mem_lat   = 1;
      mem_clr   = 1'b1;
      mem_cnt   = 0;
      mem_rvalid = 1'b0;
      mem_rdata = 32'h0;
      mem_addr  = 32'h0;

      // Reset and startup, 1-cycle memory
      tick();
      chk_out("rst1", 32'h100, 32'h0, 1'b0);
      chk("rst1.req", {31'd0, imem_req}, 32'd0);
      chk("rst1.addr", imem_addr, 32'h100);
      chk("rst1.state", {29'd0, fsm_state}, S_IDLE);
      mem_clr = 1'b0;
      tick();
      tick();
      chk("rst3.state", {29'd0, fsm_state}, S_IDLE);
      rst = 1'b1;
      tick();
      chk_req("start.a1", 1'b1, 32'h100);
      chk("start.a1.state", {29'd0, fsm_state}, S_ISSUE);
      tick();
      chk_req("start.a2", 1'b0, 32'h0);
      chk_out("start.a2", 32'h100, 32'h0, 1'b0);
      tick();
      chk_out("start.a3", 32'h100, 32'h101, 1'b1);
      chk_req("start.a3", 1'b1, 32'h104);

      // Stall across the response for 104: response goes to the skid buffer
      stall = 1'b1;
      tick();
      chk("stall.a4.state", {29'd0, fsm_state}, S_WAIT);
      chk_out("stall.a4", 32'h100, 32'h101, 1'b1);
      tick();
      chk("stall.a5.state", {29'd0, fsm_state}, S_HOLD);
      chk_out("stall.a5", 32'h100, 32'h101, 1'b1);
      tick();
      tick();
      tick();
      chk_out("stall.a8", 32'h100, 32'h101, 1'b1);
      chk_req("stall.a8", 1'b0, 32'h0);
      stall = 1'b0;
      tick();
      chk_out("stall.rel", 32'h104, 32'h105, 1'b1);
      chk_req("stall.rel", 1'b1, 32'h108);
      tick();
      chk_out("stall.bub", 32'h104, 32'h0, 1'b0);
      tick();
      chk_out("stall.next", 32'h108, 32'h109, 1'b1);

      // Redirect while waiting on a 3-cycle memory
      do_reset(3);
      tick();
      tick();
      jump_en   = 1'b1;
      jump_addr = 32'h00000203;
      tick();
      jump_en = 1'b0;
      chk("drain.a3.state", {29'd0, fsm_state}, S_DRAIN);
      chk_req("drain.a3", 1'b0, 32'h0);
      tick();
      chk("drain.a4.state", {29'd0, fsm_state}, S_DRAIN);
      tick();
      chk_req("drain.a5", 1'b1, 32'h200);
      chk_out("drain.a5", 32'h100, 32'h0, 1'b0);
      tick();
      tick();
      tick();
      chk_out("drain.a8", 32'h100, 32'h0, 1'b0);
      tick();
      chk_out("drain.a9", 32'h200, 32'h201, 1'b1);

      // Redirect coincident with rvalid while stalled
      do_reset(1);
      tick();
      tick();
      tick();
      chk_out("coin.a3", 32'h100, 32'h101, 1'b1);
      tick();
      stall     = 1'b1;
      jump_en   = 1'b1;
      jump_addr = 32'h00000200;
      tick();
      stall   = 1'b0;
      jump_en = 1'b0;
      chk_out("coin.a5", 32'h100, 32'h0, 1'b0);
      chk_req("coin.a5", 1'b1, 32'h200);
      chk("coin.a5.state", {29'd0, fsm_state}, S_ISSUE);
      tick();
      tick();
      chk_out("coin.a7", 32'h200, 32'h201, 1'b1);

      // Wrap: redirect to the last word, then fetch rolls over to 0
      tick();
      jump_en   = 1'b1;
      jump_addr = 32'hFFFFFFFE;
      tick();
      jump_en = 1'b0;
      chk_req("wrap.a9", 1'b1, 32'hFFFFFFFC);
      tick();
      tick();
      chk_out("wrap.a11", 32'hFFFFFFFC, 32'hFFFFFFFD, 1'b1);
      chk_req("wrap.a11", 1'b1, 32'h00000000);
      tick();
      tick();
      chk_out("wrap.a13", 32'h00000000, 32'h00000001, 1'b1);

      // Reset while a 3-cycle request is outstanding
      do_reset(3);
      tick();
      tick();
      chk("rmid.a2.state", {29'd0, fsm_state}, S_WAIT);
      rst = 1'b0;
      tick();
      chk("rmid.a3.state", {29'd0, fsm_state}, S_IDLE);
      chk_req("rmid.a3", 1'b0, 32'h0);
      tb_rvalid = 1'b1;
      tb_rdata  = 32'hDEADBEEF;
      tick();
      tb_rvalid = 1'b0;
      chk_out("rmid.a4", 32'h100, 32'h0, 1'b0);
      rst = 1'b1;
      tick();
      chk("rmid.a5.state", {29'd0, fsm_state}, S_ISSUE);
      chk_req("rmid.a5", 1'b1, 32'h100);
      chk_out("rmid.a5", 32'h100, 32'h0, 1'b0);
      tick();
      chk("rmid.a6.state", {29'd0, fsm_state}, S_WAIT);
      tick();
      tick();
      chk_out("rmid.a8", 32'h100, 32'h0, 1'b0);
      tick();
      chk_out("rmid.a9", 32'h100, 32'h101, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
